// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file scheduler.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_READ = 2'b11
  } op_t;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t EXEC = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  always_comb begin
    int k;
    logic [IDX_W-1:0] idx;
    k         = 0;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      k = int'(ptr) + off;
      if (k >= NREQ) k = k - NREQ;
      idx = IDX_W'(k);
      if (!grant_vld && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_sched.sv
// Two-state scheduler: accepts one op from NREQ requesters, executes it
// against an external register file in the following cycle.
module regfile_sched
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREQ   = 2,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_s,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [NREQ*ADDR_W-1:0] req_src_a,
  input  logic [NREQ*ADDR_W-1:0] req_src_b,
  input  logic [NREQ*ADDR_W-1:0] req_dst,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_raddr_1,
  output logic [ADDR_W-1:0]      rf_raddr_2,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  input  logic [DATA_W-1:0]      rf_rdata_1,
  input  logic [DATA_W-1:0]      rf_rdata_2,
  output logic                   busy,
  output logic [15:0]            ops_done
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d;
  logic [ADDR_W-1:0] src_b_q, src_b_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [15:0]       ops_done_q, ops_done_d;

  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_vld;
  logic              in_idle, in_exec, exec_live, transfer;
  logic [DATA_W-1:0] result;

  function automatic logic [DATA_W-1:0] alu(input op_t op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      default: return a;
    endcase
  endfunction

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Reset masks the EXEC cycle so an in-flight op is dropped without a write.
  assign in_idle   = (state_q == IDLE);
  assign in_exec   = (state_q == EXEC);
  assign exec_live = in_exec && !rst_s;
  assign transfer  = in_idle && grant_vld && !rst_s;
  assign result    = alu(op_q, rf_rdata_1, rf_rdata_2);

  assign req_ready  = (in_idle && !rst_s) ? grant : '0;
  assign rf_raddr_1 = in_exec ? src_a_q : '0;
  assign rf_raddr_2 = in_exec ? src_b_q : '0;
  assign rf_we      = exec_live && (op_q != OP_READ);
  assign rf_waddr   = dst_q;
  assign rf_wdata   = result;
  assign rsp_valid  = exec_live;
  assign rsp_id     = id_q;
  assign rsp_data   = result;
  assign busy       = !in_idle;
  assign ops_done   = ops_done_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_d       = op_q;
    src_a_d    = src_a_q;
    src_b_d    = src_b_q;
    dst_d      = dst_q;
    id_d       = id_q;
    ops_done_d = ops_done_q;
    if (transfer) begin
      op_d    = op_t'(req_op[int'(grant_idx)*2 +: 2]);
      src_a_d = req_src_a[int'(grant_idx)*ADDR_W +: ADDR_W];
      src_b_d = req_src_b[int'(grant_idx)*ADDR_W +: ADDR_W];
      dst_d   = req_dst[int'(grant_idx)*ADDR_W +: ADDR_W];
      id_d    = grant_idx;
      ptr_d   = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + ID_W'(1);
      state_d = EXEC;
    end else if (in_exec) begin
      state_d    = IDLE;
      ops_done_d = ops_done_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_s) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      op_q       <= OP_MOV;
      src_a_q    <= '0;
      src_b_q    <= '0;
      dst_q      <= '0;
      id_q       <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      dst_q      <= dst_d;
      id_q       <= id_d;
      ops_done_q <= ops_done_d;
    end
  end

endmodule

// File: doc/regfile_sched.md
REGFILE_SCHED -- requirements
Module: regfile_sched

Interface
REQ-001 Parameter DATA_W, 32, register width.
REQ-002 Parameter ADDR_W, 3, register address width (8 registers).
REQ-003 Parameter NREQ, 2, number of requesters.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_s  in  1  reset, synchronous, active-high; the same net also drives the register file's rst_s.
REQ-006 req_valid  in  NREQ  per-requester op valid.
REQ-007 req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
REQ-008 req_op  in  NREQx2  op code: 00 MOV, 01 ADD, 10 SUB, 11 READ.
REQ-009 req_src_a, req_src_b  in  NREQxADDR_W  source register addresses.
REQ-010 req_dst  in  NREQxADDR_W  destination register address.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_id  out  $clog2(NREQ), min 1  index of the completed requester.
REQ-013 rsp_data  out  DATA_W  result value: written value, or the A operand for READ.
REQ-014 rf_we  out  1  register file write enable.
REQ-015 rf_raddr_1, rf_raddr_2, rf_waddr  out  ADDR_W  register file addresses.
REQ-016 rf_wdata  out  DATA_W  register file write data.
REQ-017 rf_rdata_1, rf_rdata_2  in  DATA_W  register file read data, combinational from the read addresses.
REQ-018 busy  out  1  high whenever state is not IDLE.
REQ-019 ops_done  out  16  count of completed ops.

Function
REQ-020 The FSM SHALL have two states: IDLE and EXEC.
REQ-021 In IDLE, the round-robin arbiter SHALL grant the first valid requester at or after the priority pointer; req_ready[g] SHALL equal (state==IDLE) && grant[g].
REQ-022 Handshake: a transfer occurs when req_valid[i] && req_ready[i]; the requester SHALL hold the op and all addresses stable until that cycle; ready MAY depend combinationally on valid.
REQ-023 On transfer, the block SHALL latch op, src_a, src_b, dst and the requester id; move to EXEC; and set the pointer to (g+1) mod NREQ.
REQ-024 In IDLE with no valid request, state, pointer and latched fields SHALL hold.
REQ-025 In EXEC, rf_raddr_1 SHALL be latched src_a and rf_raddr_2 latched src_b. The result SHALL be: MOV=A; ADD=(A+B) mod 2^DATA_W; SUB=(A-B) mod 2^DATA_W; READ=A. Carry and borrow SHALL be discarded.
REQ-026 In EXEC, rf_we SHALL be 1 for MOV, ADD and SUB, and 0 for READ; rf_waddr=latched dst; rf_wdata=result.
REQ-027 In EXEC, rsp_valid=1, rsp_id=latched id and rsp_data=result, all combinational, in the same cycle as the write; EXEC SHALL always return to IDLE on the next edge.
REQ-028 Latency: a request transferred at edge N SHALL complete (write plus rsp_valid) in cycle N+1. Peak throughput SHALL be one op per 2 cycles.
REQ-029 When dst equals src_a or src_b, the operand SHALL be the pre-write value; the result is visible to the next op.
REQ-030 Outside EXEC, rf_we, rsp_valid and req_ready of ungranted requesters SHALL be 0; rf_raddr_1/2 SHALL be 0.
REQ-031 ops_done SHALL increment by 1 at the end of each EXEC cycle and wrap from 0xFFFF to 0.

Reset
REQ-032 When rst_s=1 at an edge, the block SHALL set state=IDLE, pointer=0, latched fields=0 and ops_done=0.
REQ-033 While rst_s=1, req_ready SHALL be 0, and rf_we and rsp_valid SHALL be 0.
REQ-034 Reset asserted during EXEC SHALL drop the op: no write and no rsp_valid in that cycle.

Structure
REQ-035 A shared package regfile_pkg SHALL hold DATA_W, ADDR_W, op_t (MOV/ADD/SUB/READ) and state_t (IDLE/EXEC).
REQ-036 Round-robin grant logic SHALL live in sub-module rr_arbiter (inputs req and ptr; outputs one-hot grant and grant index).
REQ-037 The testbench SHALL instantiate regfile_sched connected to the existing regfile and keep a shadow array of 8 registers for checking.

Verification
REQ-038 Reset for 2 cycles, then r0 req READ src_a=3 -> rsp_valid in cycle 2 after the handshake, rsp_data=0, rsp_id=0, rf_we=0.
REQ-039 r0 MOV via preload: write r1=5 and r2=7 using MOV from a seeded register, then ADD dst=3 src 1,2 -> reg3=12, rsp_data=12, ops_done incremented.
REQ-040 SUB with reg1=0, reg2=1, dst=4 -> reg4=0xFFFFFFFF; ADD with 0xFFFFFFFF+1 -> 0.
REQ-041 Both requesters held valid for 8 cycles -> grants alternate 0,1,0,1; each sees ready exactly twice; no cycle has ready=2'b11.
REQ-042 ADD dst=1 src_a=1 src_b=1 with reg1=3 -> reg1=6; an immediate READ of reg1 returns 6.
REQ-043 Assert rst_s in the EXEC cycle of an ADD -> rf_we=0, rsp_valid=0, destination unchanged, ops_done=0.
